div: RTL and testbench
======================

# div

- Iterative 32-bit signed/unsigned divider for the EX stage of the five-stage MIPS32 pipeline.
- Accepts operands from EX on a start request and computes one quotient bit per cycle (restoring algorithm).
- Returns {remainder, quotient} packed as {hi, lo}. This value travels through EX/MEM and MEM/WB and is written into the HI/LO register pair.
- EX holds the pipeline stalled until `ready_o` rises.

## Interface
- `WIDTH`, 32, operand width; result is 2*WIDTH.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; asynchronous, active-high; forces IDLE and clears all outputs.
- `signed_div_i`  in  1  1 = DIV (two's complement), 0 = DIVU.
- `opdata1_i`  in  WIDTH  dividend.
- `opdata2_i`  in  WIDTH  divisor.
- `start_i`  in  1  request; EX holds it high until it sees `ready_o`.
- `annul_i`  in  1  cancel (pipeline flush/exception); overrides `start_i`.
- `result_o`  out  2*WIDTH  [63:32] remainder (to HI), [31:0] quotient (to LO); registered.
- `ready_o`  out  1  result valid; registered.

## Operation
- **States:** IDLE, BYZERO, ON, END. Reset value: IDLE, `result_o`=0, `ready_o`=0, cnt=0.

**IDLE**
- Acts when `start_i`=1 and `annul_i`=0:
  - If `opdata2_i`=0, go to BYZERO.
  - Otherwise latch |dividend|, |divisor|, signs and `signed_div_i`, clear cnt, and go to ON.
- Absolute value is taken only when `signed_div_i`=1 and the operand's MSB is 1; otherwise the raw operand is used.

**BYZERO**
- Go to END unconditionally, loading `result_o`=0.

**ON**
- While `annul_i`=0, each cycle performs one restoring step:
  - Working 65-bit register = {partial remainder, dividend, 1'b0}.
  - Subtract the divisor from the upper 33 bits.
  - If the difference is non-negative, shift in quotient bit 1; otherwise shift in 0.
- cnt increments each step. When the step with cnt=31 completes, go to END.
- On entering END, load `result_o` with the sign-fixed result and set `ready_o`=1:
  - Quotient is negated if `signed_div_i` and the operand signs differ.
  - Remainder is negated if `signed_div_i` and the dividend is negative (remainder takes the dividend's sign).
- If `annul_i`=1 in any cycle of ON, go to IDLE at the next edge; `ready_o` stays 0 and `result_o` is unchanged.

**END**
- `ready_o`=1 and `result_o` are held while `start_i`=1 (pipeline still stalled elsewhere).
- When `start_i`=0, go to IDLE and clear `ready_o` and `result_o` to 0.
- `annul_i` in END also returns to IDLE and clears outputs.

**Other rules**
- Operand inputs are ignored after acceptance; changes during ON have no effect.
- `start_i` is ignored during ON and BYZERO.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0. This is two's-complement wrap; no trap is raised.
- Arithmetic is modulo 2^WIDTH per half; there are no status outputs.

## Timing
- Call the edge that accepts `start_i` E0.
  - Nonzero divisor: `ready_o` is high in the cycle after edge E32 (32 ON cycles), giving 33-cycle latency.
  - Zero divisor: `ready_o` is high after edge E2.
- Back-to-back operation: after `start_i` drops in END, one IDLE cycle follows, so the earliest next accept is one cycle later.
- `rst` asserted at any point clears state and outputs immediately (asynchronous), with no wait for `clk`. After deassertion the block is in IDLE.
- `annul_i` and `start_i` sampled together in IDLE: annul wins and no operation starts.

## Test plan
- **Unsigned:** DIVU 100/7.
  - `ready_o` rises 33 cycles after accept.
  - `result_o` = {0x00000002, 0x0000000E}.
  - Outputs are held while `start_i`=1 and clear the cycle after `start_i`=0.
- **Signed:** DIV −7/2 (0xFFFFFFF9/0x00000002) gives {0xFFFFFFFF, 0xFFFFFFFD}.
  - DIV 7/−2 gives {0x00000001, 0xFFFFFFFD}.
- **Divide by zero:** DIV 5/0 gives `ready_o` after 2 edges and `result_o`=0.
- **Annul:** assert `annul_i` on the 10th ON cycle.
  - State returns to IDLE and `ready_o` never asserts.
  - A new DIVU 0xFFFFFFFF/1 accepted next completes with {0, 0xFFFFFFFF}.
- **Boundaries:**
  - DIV 0x80000000/0xFFFFFFFF gives {0, 0x80000000}.
  - DIVU 0x80000000/0xFFFFFFFF gives {0x80000000, 0}.
  - DIVU 3/5 gives {3, 0}.
- **Async reset:** assert `rst` between edges mid-ON.
  - `ready_o` and `result_o` go to 0 without a clock edge.
  - After release, a fresh DIVU 100/7 completes in 33 cycles.

Source files
------------

// File: rtl/div.sv
// Iterative restoring divider for the EX stage: one quotient bit per cycle,
// returns {remainder, quotient} for the HI/LO pair; DIV and DIVU.
module div #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} state_t;

    state_t             r_state, w_state_nxt;
    logic [2*WIDTH:0]   r_work, w_work_nxt;
    logic [WIDTH-1:0]   r_divisor, w_divisor_nxt;
    logic [CW-1:0]      r_cnt, w_cnt_nxt;
    logic               r_neg_q, w_neg_q_nxt;
    logic               r_neg_r, w_neg_r_nxt;
    logic [2*WIDTH-1:0] r_result, w_result_nxt;
    logic               r_ready, w_ready_nxt;

    logic               w_accept;
    logic [WIDTH-1:0]   w_abs1, w_abs2;
    logic               w_ge;
    logic [WIDTH-1:0]   w_diff, w_rem, w_quot;
    logic               w_last;

    assign w_accept = start_i && !annul_i;
    assign w_abs1   = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign w_abs2   = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    assign w_last   = (r_cnt == CW'(WIDTH-1));

    // Trial value is the top WIDTH+1 bits; when it fits, the true difference is
    // below the divisor, so a WIDTH-bit subtraction is exact.
    assign w_ge   = (r_work[2*WIDTH:WIDTH] >= {1'b0, r_divisor});
    assign w_diff = r_work[2*WIDTH-1:WIDTH] - r_divisor;
    assign w_rem  = w_ge ? w_diff : r_work[2*WIDTH-1:WIDTH];
    assign w_quot = {r_work[WIDTH-2:0], w_ge};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_work    <= '0;
            r_divisor <= '0;
            r_cnt     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_result  <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_work    <= w_work_nxt;
            r_divisor <= w_divisor_nxt;
            r_cnt     <= w_cnt_nxt;
            r_neg_q   <= w_neg_q_nxt;
            r_neg_r   <= w_neg_r_nxt;
            r_result  <= w_result_nxt;
            r_ready   <= w_ready_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept)
                    w_state_nxt = (opdata2_i == '0) ? S_BYZERO : S_ON;
            end
            S_BYZERO: w_state_nxt = S_END;
            S_ON: begin
                if (annul_i)
                    w_state_nxt = S_IDLE;
                else if (w_last)
                    w_state_nxt = S_END;
            end
            S_END: begin
                if (annul_i || !start_i)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_work_nxt    = r_work;
        w_divisor_nxt = r_divisor;
        w_cnt_nxt     = r_cnt;
        w_neg_q_nxt   = r_neg_q;
        w_neg_r_nxt   = r_neg_r;
        w_result_nxt  = r_result;
        w_ready_nxt   = r_ready;
        case (r_state)
            S_IDLE: begin
                w_ready_nxt = 1'b0;
                if (w_accept && (opdata2_i != '0)) begin
                    w_work_nxt    = {{WIDTH{1'b0}}, w_abs1, 1'b0};
                    w_divisor_nxt = w_abs2;
                    w_cnt_nxt     = '0;
                    w_neg_q_nxt   = signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                    w_neg_r_nxt   = signed_div_i && opdata1_i[WIDTH-1];
                end
            end
            S_BYZERO: w_result_nxt = '0;
            S_ON: begin
                if (!annul_i) begin
                    w_work_nxt = {w_rem, r_work[WIDTH-1:0], w_ge};
                    w_cnt_nxt  = r_cnt + 1'b1;
                    if (w_last) begin
                        w_result_nxt = {(r_neg_r ? -w_rem : w_rem),
                                        (r_neg_q ? -w_quot : w_quot)};
                        w_ready_nxt  = 1'b1;
                    end
                end
            end
            S_END: begin
                if (annul_i || !start_i) begin
                    w_result_nxt = '0;
                    w_ready_nxt  = 1'b0;
                end else begin
                    w_ready_nxt = 1'b1;
                end
            end
            default: begin
                w_result_nxt = '0;
                w_ready_nxt  = 1'b0;
            end
        endcase
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;

endmodule

// File: tb/tb_div.sv
// Directed bench for div: latency, results, hold/clear, annul, zero divisor,
// boundary operands and asynchronous reset.
module tb_div;

    logic        clk;
    logic        rst;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    int n_checks = 0;
    int n_errors = 0;

    div #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (sgn),
        .opdata1_i    (a),
        .opdata2_i    (b),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (ready !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
    endtask

    // Latency is counted in edges after the accepting edge.
    task automatic run_op(input string tag, input logic s, input logic [31:0] x,
                          input logic [31:0] y, input logic [63:0] exp, input int lat);
        int cyc;
        sgn   = s;
        a     = x;
        b     = y;
        start = 1'b1;
        tick();
        a   = $urandom;
        b   = $urandom;
        sgn = ~s;
        wait_ready(cyc);
        check({tag, "_lat"}, 64'(cyc), 64'(lat));
        check({tag, "_res"}, result, exp);
        tick();
        check({tag, "_hold_rdy"}, {63'b0, ready}, 64'd1);
        check({tag, "_hold_res"}, result, exp);
        start = 1'b0;
        tick();
        check({tag, "_clr_rdy"}, {63'b0, ready}, 64'd0);
        check({tag, "_clr_res"}, result, 64'd0);
    endtask

    task automatic watch_idle(input string tag);
        int highs;
        highs = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ready === 1'b1) highs++;
        end
        check({tag, "_ready_highs"}, 64'(highs), 64'd0);
        check({tag, "_res"}, result, 64'd0);
    endtask

    initial begin
        int cyc;
        rst   = 1'b1;
        start = 1'b0;
        annul = 1'b0;
        sgn   = 1'b0;
        a     = '0;
        b     = '0;
        #2;
        check("reset_ready", {63'b0, ready}, 64'd0);
        check("reset_result", result, 64'd0);
        tick();
        tick();
        rst = 1'b0;

        run_op("divu_100_7",    1'b0, 32'd100,        32'd7,        64'h00000002_0000000E, 32);
        run_op("div_m7_2",      1'b1, 32'hFFFFFFF9,   32'd2,        64'hFFFFFFFF_FFFFFFFD, 32);
        run_op("div_7_m2",      1'b1, 32'd7,          32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 32);
        run_op("div_5_0",       1'b1, 32'd5,          32'd0,        64'h00000000_00000000, 2);
        run_op("div_m100_m7",   1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, 64'hFFFFFFFE_0000000E, 32);
        run_op("divu_fff9_2",   1'b0, 32'hFFFFFFF9,   32'd2,        64'h00000001_7FFFFFFC, 32);

        // Annul on the 10th ON cycle
        sgn   = 1'b0;
        a     = 32'd1000;
        b     = 32'd3;
        start = 1'b1;
        tick();
        repeat (9) @(posedge clk);
        #1;
        annul = 1'b1;
        start = 1'b0;
        tick();
        annul = 1'b0;
        watch_idle("annul_on");
        run_op("divu_ffff_1",   1'b0, 32'hFFFFFFFF,   32'd1,        64'h00000000_FFFFFFFF, 32);

        run_op("div_ovf",       1'b1, 32'h80000000,   32'hFFFFFFFF, 64'h00000000_80000000, 32);
        run_op("divu_8000_ffff",1'b0, 32'h80000000,   32'hFFFFFFFF, 64'h80000000_00000000, 32);
        run_op("divu_3_5",      1'b0, 32'd3,          32'd5,        64'h00000003_00000000, 32);
        run_op("divu_ff_fe",    1'b0, 32'hFFFFFFFF,   32'hFFFFFFFE, 64'h00000001_00000001, 32);

        // Annul together with start in IDLE: nothing starts
        sgn   = 1'b0;
        a     = 32'd100;
        b     = 32'd7;
        start = 1'b1;
        annul = 1'b1;
        tick();
        start = 1'b0;
        annul = 1'b0;
        watch_idle("annul_idle");

        // Asynchronous reset while the result is being held
        sgn   = 1'b0;
        a     = 32'd100;
        b     = 32'd7;
        start = 1'b1;
        tick();
        wait_ready(cyc);
        check("end_pre_rst_res", result, 64'h00000002_0000000E);
        #2;
        rst = 1'b1;
        #1;
        check("end_rst_ready", {63'b0, ready}, 64'd0);
        check("end_rst_result", result, 64'd0);
        tick();
        rst   = 1'b0;
        start = 1'b0;

        // Asynchronous reset mid-ON
        a     = 32'd100;
        b     = 32'd7;
        start = 1'b1;
        tick();
        repeat (15) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("on_rst_ready", {63'b0, ready}, 64'd0);
        check("on_rst_result", result, 64'd0);
        tick();
        rst   = 1'b0;
        start = 1'b0;
        run_op("post_rst_100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 32);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
